csr_row_packer: RTL and testbench

// Encoder counterpart of the CSR row fetcher: packs dense rows, streamed one row per handshake,

---
 rtl/csr_row_packer_if.sv | 29 ++
 rtl/csr_row_packer.sv | 140 ++++++++++++++
 tb/tb_csr_row_packer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_row_packer_if.sv
// Handshake bundle between the dense row producer, the CSR row packer and the
// consumer of the packed matrix. The packer sits on the slave modport.
interface csr_row_packer_if #(
  parameter int ROW_SIZE       = 4,
  parameter int OUT_SIZE       = 4,
  parameter int IN_PARALLELISM = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16
);
  logic [ROW_SIZE-1:0][DATA_WIDTH-1:0]       in_data;
  logic                                      in_valid;
  logic                                      in_ready;
  logic [OUT_SIZE-1:0][DATA_WIDTH-1:0]       out_data;
  logic [OUT_SIZE-1:0][ADDR_WIDTH-1:0]       out_index;
  logic [IN_PARALLELISM:0][ADDR_WIDTH-1:0]   out_bounds;
  logic                                      out_overflow;
  logic                                      out_valid;
  logic                                      out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_bounds, out_overflow, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_index, out_bounds, out_overflow, out_valid
  );
endinterface

// File: rtl/csr_row_packer.sv
// Packs IN_PARALLELISM dense rows, one per handshake, into a CSR matrix.
// Each accepted row is scanned one column per cycle; nonzeros are appended to
// the data/index storage until it fills, after which they are dropped and the
// sticky overflow flag is raised. The finished matrix is held on a valid/ready
// port and the storage returns to its padded reset image on handoff.
module csr_row_packer #(
  parameter int ROW_SIZE       = 4,
  parameter int OUT_SIZE       = 4,
  parameter int IN_PARALLELISM = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16
) (
  input logic               clk,
  input logic               rst,
  csr_row_packer_if.slave   bus
);

  localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int WP_W  = $clog2(OUT_SIZE + 1);
  localparam int IDX_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int ROW_W = (IN_PARALLELISM > 1) ? $clog2(IN_PARALLELISM) : 1;
  localparam int BND_W = $clog2(IN_PARALLELISM + 1);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SCAN   = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ROW_SIZE-1:0][DATA_WIDTH-1:0]     buf_q;
  logic [COL_W-1:0]                        col_q;
  logic [ROW_W-1:0]                        row_q;
  logic [WP_W-1:0]                         wp_q;
  logic [OUT_SIZE-1:0][DATA_WIDTH-1:0]     data_q;
  logic [OUT_SIZE-1:0][ADDR_WIDTH-1:0]     index_q;
  logic [IN_PARALLELISM:0][ADDR_WIDTH-1:0] bounds_q;
  logic                                    overflow_q;

  logic [DATA_WIDTH-1:0] cur_elem;
  logic                  elem_nz;
  logic                  has_room;
  logic                  last_col;
  logic                  last_row;
  logic [WP_W-1:0]       wp_next;
  logic [BND_W-1:0]      bnd_idx;
  logic [IDX_W-1:0]      wp_idx;

  // Scan-side decode: current element, room left, end-of-row/matrix markers.
  always_comb begin
    cur_elem = buf_q[col_q];
    elem_nz  = |cur_elem;
    has_room = wp_q < WP_W'(OUT_SIZE);
    last_col = col_q == COL_W'(ROW_SIZE - 1);
    last_row = row_q == ROW_W'(IN_PARALLELISM - 1);
    wp_next  = (elem_nz && has_room) ? wp_q + 1'b1 : wp_q;
    bnd_idx  = BND_W'(row_q) + 1'b1;
    wp_idx   = wp_q[IDX_W-1:0];
  end

  // Next-state logic: accept a row, scan it, and park in DONE until handoff.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT: if (bus.in_valid) state_d = SCAN;
      SCAN:   if (last_col) state_d = last_row ? DONE : ACCEPT;
      DONE:   if (bus.out_ready) state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  // State register; reset also abandons any partly scanned matrix.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ACCEPT;
    else      state_q <= state_d;
  end

  // Datapath: row capture, nonzero append, row pointer update, handoff clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wp_q       <= '0;
      data_q     <= '0;
      index_q    <= '1;
      bounds_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (bus.in_valid) begin
            buf_q <= bus.in_data;
            col_q <= '0;
          end
        end
        SCAN: begin
          if (elem_nz) begin
            if (has_room) begin
              data_q[wp_idx]  <= cur_elem;
              index_q[wp_idx] <= ADDR_WIDTH'(col_q);
            end else begin
              overflow_q <= 1'b1;
            end
          end
          wp_q <= wp_next;
          if (last_col) begin
            bounds_q[bnd_idx] <= ADDR_WIDTH'(wp_next);
            if (!last_row) row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            row_q      <= '0;
            wp_q       <= '0;
            data_q     <= '0;
            index_q    <= '1;
            bounds_q   <= '0;
            overflow_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Port drive: handshake flags follow the state, matrix comes straight from storage.
  always_comb begin
    bus.in_ready     = (state_q == ACCEPT);
    bus.out_valid    = (state_q == DONE);
    bus.out_data     = data_q;
    bus.out_index    = index_q;
    bus.out_bounds   = bounds_q;
    bus.out_overflow = overflow_q;
  end

endmodule

// File: tb/tb_csr_row_packer.sv
// Directed bench for csr_row_packer: reset image, CSR packing, overflow,
// backpressure, mid-scan reset, and a streaming run against a software encoder.
module tb_csr_row_packer;

  localparam int RS = 4;
  localparam int OS = 4;
  localparam int IP = 3;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk;
  logic rst;
  int   cycle;
  int   test_count;
  int   fail_count;

  csr_row_packer_if #(
    .ROW_SIZE(RS), .OUT_SIZE(OS), .IN_PARALLELISM(IP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) bus ();

  csr_row_packer #(
    .ROW_SIZE(RS), .OUT_SIZE(OS), .IN_PARALLELISM(IP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [RS-1:0][DW-1:0]   row_mem [IP];
  logic [OS-1:0][DW-1:0]   exp_data;
  logic [OS-1:0][AW-1:0]   exp_index;
  logic [IP:0][AW-1:0]     exp_bounds;
  logic                    exp_ovf;
  logic [OS-1:0][DW-1:0]   obs_data;
  logic [OS-1:0][AW-1:0]   obs_index;
  logic [IP:0][AW-1:0]     obs_bounds;
  logic [RS-1:0][DW-1:0]   dense;
  int                      acc_cycle [IP];
  logic                    stable;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure handshake spacing.
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [63:0] pack4(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then completes one row handshake.
  task automatic apply_stimulus(input logic [RS-1:0][DW-1:0] row);
    int k;
    bus.in_data  = row;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      tick();
      k++;
    end
    check_output("in_ready_wait", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!bus.out_valid && k < 100) begin
      tick();
      k++;
    end
    check_output(tag, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check_output({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, "_data"}, 64'(bus.out_data), 64'd0);
    check_output({tag, "_index"}, 64'(bus.out_index), {64{1'b1}});
    check_output({tag, "_bounds"}, 64'(bus.out_bounds), 64'd0);
    check_output({tag, "_ovf"}, 64'(bus.out_overflow), 64'd0);
  endtask

  // Reference software CSR encoder over row_mem.
  task automatic model_encode();
    int wp;
    wp = 0;
    exp_data   = '0;
    exp_index  = '1;
    exp_bounds = '0;
    exp_ovf    = 1'b0;
    for (int r = 0; r < IP; r++) begin
      for (int j = 0; j < RS; j++) begin
        if (row_mem[r][j] != '0) begin
          if (wp < OS) begin
            exp_data[wp]  = row_mem[r][j];
            exp_index[wp] = AW'(j);
            wp++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
      exp_bounds[r+1] = AW'(wp);
    end
  endtask

  initial begin
    cycle        = 0;
    test_count   = 0;
    fail_count   = 0;
    rst          = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held low for three edges.
    tick(); tick(); tick();
    check_cleared("reset");
    rst = 1'b1;

    // Rows {0,5,0,7},{0,0,0,0},{9,0,0,0} with out_valid timing.
    apply_stimulus(pack4(16'd0, 16'd5, 16'd0, 16'd7));
    check_output("scan_in_ready", 64'(bus.in_ready), 64'd0);
    apply_stimulus(pack4(16'd0, 16'd0, 16'd0, 16'd0));
    apply_stimulus(pack4(16'd9, 16'd0, 16'd0, 16'd0));
    tick(); tick(); tick();
    check_output("valid_early", 64'(bus.out_valid), 64'd0);
    tick();
    check_output("valid_rise", 64'(bus.out_valid), 64'd1);
    check_output("c2_data", 64'(bus.out_data), pack4(16'd5, 16'd7, 16'd9, 16'd0));
    check_output("c2_index", 64'(bus.out_index), pack4(16'd1, 16'd3, 16'd0, 16'hFFFF));
    check_output("c2_bounds", 64'(bus.out_bounds), pack4(16'd0, 16'd2, 16'd2, 16'd3));
    check_output("c2_ovf", 64'(bus.out_overflow), 64'd0);

    // Backpressure for 20 cycles with in_valid asserted; matrix must hold still.
    bus.in_valid = 1'b1;
    bus.in_data  = pack4(16'd1, 16'd1, 16'd1, 16'd1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.out_valid || bus.in_ready ||
          bus.out_data !== pack4(16'd5, 16'd7, 16'd9, 16'd0) ||
          bus.out_bounds !== pack4(16'd0, 16'd2, 16'd2, 16'd3))
        stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    check_output("bp_stable", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_cleared("handoff");

    // Overflow case.
    apply_stimulus(pack4(16'd1, 16'd2, 16'd3, 16'd0));
    apply_stimulus(pack4(16'd4, 16'd5, 16'd0, 16'd0));
    apply_stimulus(pack4(16'd0, 16'd0, 16'd0, 16'd6));
    wait_valid("c3_valid");
    check_output("c3_data", 64'(bus.out_data), pack4(16'd1, 16'd2, 16'd3, 16'd4));
    check_output("c3_index", 64'(bus.out_index), pack4(16'd0, 16'd1, 16'd2, 16'd0));
    check_output("c3_bounds", 64'(bus.out_bounds), pack4(16'd0, 16'd3, 16'd4, 16'd4));
    check_output("c3_ovf", 64'(bus.out_overflow), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset during the scan of row 2, after overflow has already been set.
    apply_stimulus(pack4(16'd1, 16'd2, 16'd3, 16'd0));
    apply_stimulus(pack4(16'd4, 16'd5, 16'd0, 16'd0));
    apply_stimulus(pack4(16'd7, 16'd0, 16'd0, 16'd6));
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_cleared("midscan_reset");
    apply_stimulus(pack4(16'd0, 16'd0, 16'd3, 16'd0));
    apply_stimulus(pack4(16'd8, 16'd0, 16'd0, 16'd0));
    apply_stimulus(pack4(16'd0, 16'd0, 16'd0, 16'd0));
    wait_valid("c5_valid");
    check_output("c5_data", 64'(bus.out_data), pack4(16'd3, 16'd8, 16'd0, 16'd0));
    check_output("c5_index", 64'(bus.out_index), pack4(16'd2, 16'd0, 16'hFFFF, 16'hFFFF));
    check_output("c5_bounds", 64'(bus.out_bounds), pack4(16'd0, 16'd1, 16'd2, 16'd2));
    check_output("c5_ovf", 64'(bus.out_overflow), 64'd0);
    bus.out_ready = 1'b1;
    tick();

    // Streaming: in_valid held high, consumer always ready, random sparse rows.
    bus.in_valid = 1'b1;
    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < IP; r++)
        for (int j = 0; j < RS; j++)
          row_mem[r][j] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(1, 65535)) : '0;
      model_encode();
      for (int r = 0; r < IP; r++) begin
        int k;
        bus.in_data = row_mem[r];
        k = 0;
        while (!bus.in_ready && k < 100) begin
          tick();
          k++;
        end
        check_output("stream_ready", 64'(bus.in_ready), 64'd1);
        tick();
        acc_cycle[r] = cycle;
      end
      check_output("stream_gap01", 64'(acc_cycle[1] - acc_cycle[0]), 64'd5);
      check_output("stream_gap12", 64'(acc_cycle[2] - acc_cycle[1]), 64'd5);
      wait_valid("stream_valid");
      obs_data   = bus.out_data;
      obs_index  = bus.out_index;
      obs_bounds = bus.out_bounds;
      check_output("stream_data", 64'(obs_data), 64'(exp_data));
      check_output("stream_index", 64'(obs_index), 64'(exp_index));
      check_output("stream_bounds", 64'(obs_bounds), 64'(exp_bounds));
      check_output("stream_ovf", 64'(bus.out_overflow), 64'(exp_ovf));
      if (!exp_ovf) begin
        for (int r = 0; r < IP; r++) begin
          dense = '0;
          for (int p = int'(obs_bounds[r]); p < int'(obs_bounds[r+1]) && p < OS; p++)
            dense[obs_index[p][1:0]] = obs_data[p];
          check_output("stream_readback", 64'(dense), 64'(row_mem[r]));
        end
      end
    end
    bus.in_valid  = 1'b0;
    tick();
    bus.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
